alu_operand_entry: RTL and testbench
====================================

Name: alu_operand_entry

Overview:
Input-side front end for the board-level ALU demo. It debounces the raw push-buttons and runs an entry FSM that captures port A, port B and the ALU opcode from the switches, one step per button press. It then presents the completed operand set to the ALU datapath over a valid/ready handshake. It sits between the board pins (KEY, SW) and the ALU interface, and replaces the direct switch/key wiring.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a button level change (10 ms at 50 MHz); legal range 1 to 2^20-1.

Ports:
- CLK, input, 1: system clock; all state updates on the rising edge.
- nRST, input, 1: asynchronous, active-low reset.
- KEY, input, 4: raw push-buttons, active-low, asynchronous to CLK. KEY[0] is ENTER, KEY[3] is CANCEL, KEY[2:1] unused.
- SW, input, 18: slide switches, sampled through a 2-flop synchronizer.
- ready, input, 1: the ALU side accepts the operand set this cycle.
- valid, output, 1: the operand set is complete and stable.
- portA, output, 32: captured operand A.
- portB, output, 32: captured operand B.
- aluop, output, 4: captured opcode.
- entry_state, output, 2: current FSM state for the LEDs. 00 = GET_A, 01 = GET_B, 10 = GET_OP, 11 = ISSUE.

Behaviour:
- Reset (asynchronous, while nRST = 0):
  - valid = 0; portA = portB = 0; aluop = 0; entry_state = GET_A.
  - Debounce counters = 0; debounced key levels = released (1); synchronizer flops = 1.
- Synchronization: each KEY bit and all SW bits pass through 2 flops before any use.
- Debounce, per key:
  - The counter increments while the synchronized level differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A press event is a 1-cycle pulse, registered on the debounced 1->0 transition. A release produces no event.
- Latency: KEY held low from the first sampling edge E gives the FSM transition on edge E+DEBOUNCE_CYCLES+3. A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- Sign extension: the operand value is {{16{SW[16]}}, SW[15:0]}, using synchronized SW.
- FSM transitions:
  - GET_A + ENTER: portA <= operand value; go to GET_B.
  - GET_B + ENTER: portB <= operand value; go to GET_OP.
  - GET_OP + ENTER: aluop <= SW[3:0]; go to ISSUE; valid goes to 1 on the same edge.
  - ISSUE: valid = 1 and portA/portB/aluop are held constant. ENTER is ignored.
  - ISSUE with ready = 1 at an edge: the transfer completes, valid = 0 next cycle, go to GET_A. portA/portB/aluop keep their values until overwritten.
- CANCEL event in any state:
  - Go to GET_A and set valid = 0 next cycle.
  - Captured registers are not cleared.
  - In ISSUE, CANCEL has priority over ready: no transfer occurs.
- Simultaneous events:
  - ENTER and CANCEL events in the same cycle: CANCEL wins; ENTER is discarded.
  - Both buttons are debounced independently.
- ready outside ISSUE is ignored.
- valid is a registered output, glitch-free, and depends on no combinational path from ready.
- Reset mid-debounce or mid-entry: everything returns to reset values immediately. A press held through reset deassertion generates a new event only after a full DEBOUNCE_CYCLES stable interval, counted from release of reset.
- Width rule: SW[17] is unused by this block.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Full entry:
   - Stimulus: SW = 0x0_0005, press ENTER; SW = 0x1_FFFE, press ENTER; SW[3:0] = 0x2, press ENTER; ready held 0.
   - Required: portA = 0x00000005, portB = 0xFFFFFFFE, aluop = 0x2, valid = 1, entry_state = 11.
   - Then ready = 1 for 1 cycle: valid = 0 and entry_state = 00 on the following cycle.
2. Bounce rejection:
   - Stimulus: KEY[0] toggles low/high every 2 cycles for 20 cycles, then stays low.
   - Required: exactly one state advance, occurring 7 edges after the stable low starts.
3. Long hold:
   - Stimulus: KEY[0] held low for 100 cycles.
   - Required: exactly one advance (GET_A -> GET_B); no further advance until release plus a new press.
4. Cancel in ISSUE:
   - Stimulus: reach ISSUE; assert ready = 1 on the same edge the CANCEL event fires.
   - Required: no transfer counted, valid = 0 next cycle, entry_state = 00, portA/portB/aluop unchanged.
5. Simultaneous ENTER and CANCEL in GET_B:
   - Required: entry_state = 00; portB unchanged.
6. Asynchronous reset:
   - Stimulus: drop nRST mid-way through GET_OP, between clock edges.
   - Required: outputs read reset values immediately, without waiting for a clock edge. KEY[0] held low across reset release gives no event until 4 stable samples plus pipeline latency have elapsed.

Source files
------------

// File: rtl/alu_operand_entry.sv
// alu_operand_entry
//   Board-side front end for the ALU demo. Debounces the ENTER/CANCEL push
//   buttons and walks an entry FSM that captures operand A, operand B and the
//   opcode from the slide switches. The completed set is offered to the ALU
//   over a valid/ready handshake.
//
//   Ports
//     CLK          system clock, rising edge
//     nRST         asynchronous active-low reset
//     KEY[3:0]     raw push-buttons, active-low (KEY[0] ENTER, KEY[3] CANCEL)
//     SW[17:0]     slide switches (SW[17] unused)
//     ready        ALU accepts the operand set this cycle
//     valid        operand set complete and stable (registered)
//     portA/portB  captured 32-bit operands (sign-extended from SW[16:0])
//     aluop        captured 4-bit opcode
//     entry_state  FSM state for the LEDs: 00 A, 01 B, 10 OP, 11 ISSUE

// Per-key synchronizer + debouncer. Emits a one-cycle press pulse on the
// debounced 1->0 transition; releases produce nothing.
module alu_operand_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_raw,
    output logic press
);
    // Counter wraps to zero on the D-th consecutive differing sample,
    // which is the same edge the debounced level flips.
    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync;
    logic        level;
    logic        level_d;
    logic [19:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync    <= 2'b11;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[0], key_raw};
            level_d <= level;
            press   <= level_d & ~level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end
endmodule

module alu_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluop,
    output logic [1:0]  entry_state
);
    localparam int NUM_KEYS = 2;  // 0: ENTER, 1: CANCEL

    typedef enum logic [1:0] {
        GET_A  = 2'b00,
        GET_B  = 2'b01,
        GET_OP = 2'b10,
        ISSUE  = 2'b11
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] key_sel;
    logic [NUM_KEYS-1:0] press;
    logic [16:0]         sw_s1;
    logic [16:0]         sw_s2;
    logic [31:0]         operand;
    logic                enter_ev;
    logic                cancel_ev;
    logic                unused_pins;

    assign unused_pins = ^{KEY[2:1], SW[17]};
    assign key_sel     = {KEY[3], KEY[0]};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        alu_operand_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLK     (CLK),
            .nRST    (nRST),
            .key_raw (key_sel[g]),
            .press   (press[g])
        );
    end

    assign enter_ev  = press[0];
    assign cancel_ev = press[1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sw_s1 <= '1;
            sw_s2 <= '1;
        end else begin
            sw_s1 <= SW[16:0];
            sw_s2 <= sw_s1;
        end
    end

    assign operand = {{16{sw_s2[16]}}, sw_s2[15:0]};

    // CANCEL outranks both ENTER and a pending ready in ISSUE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= GET_A;
            valid <= 1'b0;
            portA <= '0;
            portB <= '0;
            aluop <= '0;
        end else if (cancel_ev) begin
            state <= GET_A;
            valid <= 1'b0;
        end else begin
            case (state)
                GET_A: if (enter_ev) begin
                    portA <= operand;
                    state <= GET_B;
                end
                GET_B: if (enter_ev) begin
                    portB <= operand;
                    state <= GET_OP;
                end
                GET_OP: if (enter_ev) begin
                    aluop <= sw_s2[3:0];
                    state <= ISSUE;
                    valid <= 1'b1;
                end
                ISSUE: if (ready) begin
                    state <= GET_A;
                    valid <= 1'b0;
                end
                default: state <= GET_A;
            endcase
        end
    end

    assign entry_state = state;
endmodule

// File: tb/tb_alu_operand_entry.sv
`timescale 1ns/1ps
module tb_alu_operand_entry;
    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  KEY = 4'hF;
    logic [17:0] SW = '0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] portA, portB;
    logic [3:0]  aluop;
    logic [1:0]  entry_state;

    alu_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK(CLK), .nRST(nRST), .KEY(KEY), .SW(SW), .ready(ready),
        .valid(valid), .portA(portA), .portB(portB), .aluop(aluop),
        .entry_state(entry_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: raw-sample run lengths decide debounced levels; a
    // press accepted on the D-th low sample acts on the FSM 4 edges later.
    int          cyc = 0;
    logic        m_db [2];
    int          m_run [2];
    int          ev_q [2][$];
    logic [17:0] sw_d1, sw_d2;
    logic [1:0]  m_state;
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_db[i] = 1'b1; m_run[i] = 0; ev_q[i].delete();
        end
        sw_d1 = '1; sw_d2 = '1;
        m_state = 2'd0; m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0;
    endtask

    task automatic tick();
        logic [1:0]  k;
        logic        r;
        logic [31:0] opnd;
        bit          ent, can;
        k = {KEY[3], KEY[0]};
        r = ready;
        @(posedge CLK);
        cyc++;
        if (!nRST) begin
            model_reset();
        end else begin
            ent = 0; can = 0;
            if (ev_q[0].size() > 0 && ev_q[0][0] == cyc) begin ent = 1; void'(ev_q[0].pop_front()); end
            if (ev_q[1].size() > 0 && ev_q[1][0] == cyc) begin can = 1; void'(ev_q[1].pop_front()); end
            opnd = {{16{sw_d2[16]}}, sw_d2[15:0]};
            if (can) begin
                m_state = 2'd0; m_valid = 1'b0;
            end else begin
                case (m_state)
                    2'd0: if (ent) begin m_a = opnd; m_state = 2'd1; end
                    2'd1: if (ent) begin m_b = opnd; m_state = 2'd2; end
                    2'd2: if (ent) begin m_op = sw_d2[3:0]; m_state = 2'd3; m_valid = 1'b1; end
                    default: if (r) begin m_state = 2'd0; m_valid = 1'b0; end
                endcase
            end
            for (int i = 0; i < 2; i++) begin
                if (k[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i] = k[i];
                        m_run[i] = 0;
                        if (k[i] == 1'b0) ev_q[i].push_back(cyc + 4);
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            sw_d2 = sw_d1;
            sw_d1 = SW;
        end
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        KEY = KEY & ~mask;
        repeat (hold) tick();
        KEY = KEY | mask;
        repeat (D + 6) tick();
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if ({valid, entry_state, portA, portB, aluop} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b st=%b A=%h B=%h op=%h required all zero",
                     valid, entry_state, portA, portB, aluop);
        end
        repeat (3) tick();
        #2 nRST = 1'b1;
        repeat (D + 6) tick();
        checks++;
        if ({valid, entry_state, portA, portB, aluop} !== {m_valid, m_state, m_a, m_b, m_op}) begin
            errors++;
            $display("FAIL reset_idle: got st=%b v=%b required st=%b v=%b", entry_state, valid, m_state, m_valid);
        end
    endtask

    task automatic test_full_entry();
        SW = 18'h0_0005; press(4'b0001, D + 2);
        SW = 18'h1_FFFE; press(4'b0001, D + 2);
        SW = 18'h0_0002; press(4'b0001, D + 2);
        checks++;
        if ({portA, portB, aluop, valid, entry_state} !== {32'h5, 32'hFFFFFFFE, 4'h2, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL full_entry: got A=%h B=%h op=%h v=%b st=%b required 00000005 fffffffe 2 1 11",
                     portA, portB, aluop, valid, entry_state);
        end
        checks++;
        if ({portA, portB, aluop, valid, entry_state} !== {m_a, m_b, m_op, m_valid, m_state}) begin
            errors++;
            $display("FAIL full_entry_model: got A=%h B=%h required A=%h B=%h", portA, portB, m_a, m_b);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        checks++;
        if ({valid, entry_state, portA} !== {1'b0, 2'b00, 32'h5}) begin
            errors++;
            $display("FAIL transfer: got v=%b st=%b A=%h required 0 00 00000005", valid, entry_state, portA);
        end
        repeat (3) tick();
        checks++;
        if ({valid, entry_state} !== {m_valid, m_state}) begin
            errors++;
            $display("FAIL ready_ignored: got v=%b st=%b required v=%b st=%b", valid, entry_state, m_valid, m_state);
        end
    endtask

    task automatic test_bounce();
        int adv = 0, at = -1;
        logic [1:0] prev;
        prev = entry_state;
        for (int i = 0; i < 20; i++) begin
            KEY[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (entry_state !== prev) adv++;
            prev = entry_state;
        end
        KEY[0] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (entry_state !== prev) begin adv++; if (at < 0) at = j; end
            prev = entry_state;
        end
        checks++;
        if (adv !== 1 || at !== 7) begin
            errors++;
            $display("FAIL bounce: got %0d advances at edge %0d required 1 at edge 7", adv, at);
        end
        checks++;
        if (entry_state !== m_state || entry_state !== 2'b01) begin
            errors++;
            $display("FAIL bounce_state: got %b required 01 (model %b)", entry_state, m_state);
        end
        KEY[0] = 1'b1;
        repeat (D + 6) tick();
    endtask

    task automatic test_long_hold();
        int adv = 0;
        logic [1:0] prev;
        press(4'b1000, D + 2);
        checks++;
        if (entry_state !== 2'b00) begin
            errors++;
            $display("FAIL cancel_to_a: got %b required 00", entry_state);
        end
        prev = entry_state;
        KEY[0] = 1'b0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (entry_state !== prev) adv++;
            prev = entry_state;
        end
        KEY[0] = 1'b1;
        repeat (D + 6) tick();
        checks++;
        if (adv !== 1 || entry_state !== 2'b01) begin
            errors++;
            $display("FAIL long_hold: got %0d advances st=%b required 1 advance st=01", adv, entry_state);
        end
        press(4'b0001, D);
        checks++;
        if (entry_state !== 2'b10 || entry_state !== m_state) begin
            errors++;
            $display("FAIL repress: got %b required 10 (model %b)", entry_state, m_state);
        end
    endtask

    task automatic test_cancel_issue();
        logic [31:0] sa, sb;
        logic [3:0]  so;
        press(4'b1000, D);
        for (int s = 0; s < 3; s++) begin
            SW = 18'($urandom);
            press(4'b0001, D + 1);
        end
        checks++;
        if ({entry_state, valid, portA, portB, aluop} !== {2'b11, 1'b1, m_a, m_b, m_op}) begin
            errors++;
            $display("FAIL issue_reach: got st=%b v=%b A=%h B=%h op=%h required st=11 v=1 A=%h B=%h op=%h",
                     entry_state, valid, portA, portB, aluop, m_a, m_b, m_op);
        end
        sa = m_a; sb = m_b; so = m_op;
        KEY[3] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        KEY[3] = 1'b1;
        checks++;
        if ({valid, entry_state, portA, portB, aluop} !== {1'b0, 2'b00, sa, sb, so}) begin
            errors++;
            $display("FAIL cancel_issue: got v=%b st=%b A=%h B=%h op=%h required v=0 st=00 A=%h B=%h op=%h",
                     valid, entry_state, portA, portB, aluop, sa, sb, so);
        end
        repeat (D + 6) tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] sb;
        SW = 18'($urandom);
        press(4'b0001, D);
        sb = portB;
        SW = ~SW;
        press(4'b1001, D + 1);
        checks++;
        if ({entry_state, portB} !== {2'b00, sb}) begin
            errors++;
            $display("FAIL simultaneous: got st=%b B=%h required st=00 B=%h", entry_state, portB, sb);
        end
        checks++;
        if ({entry_state, valid, portA, portB} !== {m_state, m_valid, m_a, m_b}) begin
            errors++;
            $display("FAIL simultaneous_model: got st=%b A=%h required st=%b A=%h", entry_state, portA, m_state, m_a);
        end
    endtask

    task automatic test_async_reset();
        int at = -1;
        SW = 18'($urandom); press(4'b0001, D);
        SW = 18'($urandom); press(4'b0001, D);
        checks++;
        if (entry_state !== 2'b10) begin
            errors++;
            $display("FAIL reach_get_op: got %b required 10", entry_state);
        end
        KEY[0] = 1'b0;
        #2 nRST = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({valid, entry_state, portA, portB, aluop} !== 71'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b st=%b A=%h B=%h op=%h required all zero",
                     valid, entry_state, portA, portB, aluop);
        end
        repeat (2) tick();
        #2 nRST = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (entry_state !== 2'b00 && at < 0) at = j;
        end
        checks++;
        if (at !== 7) begin
            errors++;
            $display("FAIL held_through_reset: got first advance at edge %0d required 7", at);
        end
        KEY[0] = 1'b1;
        repeat (D + 6) tick();
        checks++;
        if ({entry_state, portA} !== {m_state, m_a}) begin
            errors++;
            $display("FAIL post_reset_model: got st=%b A=%h required st=%b A=%h", entry_state, portA, m_state, m_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) KEY[0] = ~KEY[0];
            if ($urandom_range(0, 11) == 0) KEY[3] = ~KEY[3];
            if ($urandom_range(0, 3) == 0) SW = 18'($urandom);
            ready = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if ({valid, entry_state, portA, portB, aluop} !== {m_valid, m_state, m_a, m_b, m_op}) begin
                errors++;
                $display("FAIL random_%0d: got v=%b st=%b A=%h B=%h op=%h required v=%b st=%b A=%h B=%h op=%h",
                         n, valid, entry_state, portA, portB, aluop, m_valid, m_state, m_a, m_b, m_op);
            end
        end
        ready = 1'b0;
        KEY = 4'hF;
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_bounce();
        test_long_hold();
        test_cancel_issue();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
